// File: rtl/tdm_demux_1to4.sv
// Time-division 1-to-4 demultiplexer: steers rotating lane beats of a shared
// stream to four registered output lanes, with slot counter and lock FSM.
module tdm_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] y,
  output logic [3:0]         lane_valid,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t     state;
  logic [1:0] slot;

  // Single registered FSM: pulses default low and are raised only by an accepted
  // beat or a framing violation; idle cycles hold lanes, slot and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      y          <= '0;
      lane_valid <= 4'b0000;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      lane_valid <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              y[0 +: WIDTH] <= din;
              lane_valid    <= 4'b0001;
              slot          <= 2'd1;
              state         <= LOCKED;
              locked        <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync with slot!=0 abandons the partial frame and restarts it.
              y[0 +: WIDTH] <= din;
              lane_valid    <= 4'b0001;
              slot          <= 2'd1;
              if (slot != 2'd0) sync_err <= 1'b1;
            end else if (slot == 2'd0) begin
              sync_err <= 1'b1;
              slot     <= 2'd0;
              state    <= HUNT;
              locked   <= 1'b0;
            end else begin
              // Slot 3 is only reachable through an in-order run from a lane-0 beat.
              y[slot*WIDTH +: WIDTH] <= din;
              lane_valid             <= 4'b0001 << slot;
              slot                   <= slot + 2'd1;
              if (slot == 2'd3) frame_done <= 1'b1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
